// File: rtl/mp_add_seq_pkg.sv
// Shared types and defaults for the multi-precision add/sub sequencer.
// Holds the FSM state encoding, default slice geometry and the word-index width helper.
package mp_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RED  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEF_WIDTH  = 64;
   localparam int DEF_NWORDS = 4;

   // Never returns less than 1, so a single-word build still gets a legal index vector.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Request/response bundle between the arithmetic controller (master) and mp_add_seq (slave).
// Carries the modulus p only when MOD_REDUCE_EN is defined.
interface mp_add_seq_if #(
   parameter int WIDTH  = 64,
   parameter int NWORDS = 4
);
   localparam int N = WIDTH * NWORDS;

   logic         start_valid;
   logic         start_ready;
   logic         op_sub;
   logic [N-1:0] a;
   logic [N-1:0] b;
`ifdef MOD_REDUCE_EN
   logic [N-1:0] p;
`endif
   logic         res_valid;
   logic         res_ready;
   logic [N-1:0] res;
   logic         carry_out;

   modport master (
      output start_valid, op_sub, a, b,
`ifdef MOD_REDUCE_EN
      output p,
`endif
      output res_ready,
      input  start_ready, res_valid, res, carry_out
   );

   modport slave (
      input  start_valid, op_sub, a, b,
`ifdef MOD_REDUCE_EN
      input  p,
`endif
      input  res_ready,
      output start_ready, res_valid, res, carry_out
   );

endinterface

// File: rtl/mp_add_seq_slice.sv
// Single WIDTH-bit ripple adder slice shared by every word of every pass.
// Purely combinational; the caller supplies pre-inverted operands for subtraction.
module mp_add_slice
   import mp_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] sum;

   assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign s    = sum[WIDTH-1:0];
   assign cout = sum[WIDTH];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/sub sequencer: one WIDTH-bit slice stepped over NWORDS words, LSW first.
// Optional modular correction pass (state RED) is built when MOD_REDUCE_EN is defined.
module mp_add_seq
   import mp_add_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NWORDS = DEF_NWORDS
) (
   input  logic         clk,
   input  logic         rst_n,
   mp_add_seq_if.slave  bus
);

   localparam int N  = WIDTH * NWORDS;
   localparam int IW = clog2(NWORDS);
   localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

   state_t            state, state_nx;
   logic [IW-1:0]     idx;
   logic              c;
   logic              op;
   logic [N-1:0]      a_sr, b_sr, res_sr;
   logic              co_r;
   logic              accept, last_word;
   logic [WIDTH-1:0]  sl_a, sl_b, sl_s;
   logic              sl_cout;
`ifdef MOD_REDUCE_EN
   logic [N-1:0]      p_sr;
   logic              red_sel;
`endif

   // Drop the low word and insert a new word at the top (works for NWORDS == 1 too).
   function automatic logic [N-1:0] shift_in(input logic [N-1:0] v, input logic [WIDTH-1:0] w);
      return (v >> WIDTH) | (N'(w) << (N - WIDTH));
   endfunction

   assign accept    = bus.start_valid && (state == IDLE);
   assign last_word = (idx == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.start_valid) state_nx = RUN;
`ifdef MOD_REDUCE_EN
         RUN:  if (last_word) state_nx = RED;
         RED:  if (last_word) state_nx = DONE;
`else
         RUN:  if (last_word) state_nx = DONE;
`endif
         DONE: if (bus.res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.start_ready = (state == IDLE);
      bus.res_valid   = (state == DONE);
   end

   assign bus.res       = res_sr;
   assign bus.carry_out = co_r;

   // The correction pass feeds the stored result against p (inverted for the add case, cin=1).
   always_comb begin
      sl_a = a_sr[WIDTH-1:0];
      sl_b = b_sr[WIDTH-1:0];
`ifdef MOD_REDUCE_EN
      if (state == RED) begin
         sl_a = res_sr[WIDTH-1:0];
         sl_b = p_sr[WIDTH-1:0] ^ {WIDTH{~op}};
      end
`endif
   end

   mp_add_slice #(.WIDTH(WIDTH)) u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (c),
      .s    (sl_s),
      .cout (sl_cout)
   );

   // Operand shifters; during RED a_sr is reused to assemble the candidate t.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sr <= bus.a;
         b_sr <= bus.op_sub ? ~bus.b : bus.b;
`ifdef MOD_REDUCE_EN
         p_sr <= bus.p;
`endif
      end else if (state == RUN) begin
         a_sr <= a_sr >> WIDTH;
         b_sr <= b_sr >> WIDTH;
`ifdef MOD_REDUCE_EN
      end else if (state == RED) begin
         a_sr <= shift_in(a_sr, sl_s);
         p_sr <= shift_in(p_sr, p_sr[WIDTH-1:0]);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx    <= '0;
         c      <= 1'b0;
         op     <= 1'b0;
         res_sr <= '0;
         co_r   <= 1'b0;
`ifdef MOD_REDUCE_EN
         red_sel <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op <= bus.op_sub;
                  c  <= bus.op_sub;
               end
            end
            RUN: begin
               res_sr <= shift_in(res_sr, sl_s);
               idx    <= last_word ? '0 : idx + 1'b1;
               c      <= sl_cout;
               if (last_word) begin
                  co_r <= sl_cout;
`ifdef MOD_REDUCE_EN
                  c       <= ~op;
                  red_sel <= op ? ~sl_cout : sl_cout;
`endif
               end
            end
`ifdef MOD_REDUCE_EN
            // res_sr rotates in place so it is intact if the correction is rejected.
            RED: begin
               idx <= last_word ? '0 : idx + 1'b1;
               c   <= sl_cout;
               if (last_word && (red_sel || (!op && sl_cout)))
                  res_sr <= shift_in(a_sr, sl_s);
               else
                  res_sr <= shift_in(res_sr, res_sr[WIDTH-1:0]);
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed plus randomized bench for mp_add_seq at WIDTH=4, NWORDS=2 (8-bit operands).
// Honours MOD_REDUCE_EN to match the DUT build.
module tb_mp_add_seq;

   localparam int WIDTH  = 4;
   localparam int NWORDS = 2;
`ifdef MOD_REDUCE_EN
   localparam int LAT = 2 * NWORDS + 1;
`else
   localparam int LAT = NWORDS + 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mp_add_seq_if #(.WIDTH(WIDTH), .NWORDS(NWORDS)) bus ();

   mp_add_seq #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on whole operands; returns {carry_out, res}.
   function automatic logic [8:0] model(input logic op, input int a, input int b, input int p);
      int s;
      logic co;
      if (!op) begin
         s  = a + b;
         co = (s >= 256);
`ifdef MOD_REDUCE_EN
         if (s >= p) s = s - p;
`endif
      end else begin
         s  = a - b;
         co = (a >= b);
`ifdef MOD_REDUCE_EN
         if (s < 0) s = s + p;
`endif
      end
      s = (s + 256) % 256;
      return {co, s[7:0]};
   endfunction

   // Entered and left just after a negative edge.
   task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] p, input logic [7:0] exp_res, input logic exp_co,
                         input int hold, input string tag);
      int lat;
      logic [7:0] r0;
      logic c0;
      bus.op_sub = op;
      bus.a = a;
      bus.b = b;
`ifdef MOD_REDUCE_EN
      bus.p = p;
`endif
      bus.start_valid = 1'b1;
      check({tag, ".ready_idle"}, {31'b0, bus.start_ready}, 32'd1);
      @(negedge clk);
      bus.start_valid = 1'b0;
      bus.a = ~a;
      bus.b = ~b;
      lat = 1;
      check({tag, ".ready_busy"}, {31'b0, bus.start_ready}, 32'd0);
      while (!bus.res_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, lat, LAT);
      check({tag, ".res"}, {24'b0, bus.res}, {24'b0, exp_res});
      check({tag, ".carry"}, {31'b0, bus.carry_out}, {31'b0, exp_co});
      r0 = bus.res;
      c0 = bus.carry_out;
      for (int i = 0; i < hold; i++) begin
         bus.start_valid = 1'b1;
         bus.op_sub = 1'($urandom);
         bus.a = 8'($urandom);
         bus.b = 8'($urandom);
         @(negedge clk);
         check({tag, ".hold_res"}, {24'b0, bus.res}, {24'b0, r0});
         check({tag, ".hold_carry"}, {31'b0, bus.carry_out}, {31'b0, c0});
         check({tag, ".hold_valid"}, {31'b0, bus.res_valid}, 32'd1);
         check({tag, ".hold_ready"}, {31'b0, bus.start_ready}, 32'd0);
      end
      bus.start_valid = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check({tag, ".release_valid"}, {31'b0, bus.res_valid}, 32'd0);
      check({tag, ".release_ready"}, {31'b0, bus.start_ready}, 32'd1);
   endtask

   initial begin
      logic [8:0] m;
      logic [7:0] ra, rb, rp;
      logic       rop;
      bus.start_valid = 1'b0;
      bus.op_sub = 1'b0;
      bus.a = '0;
      bus.b = '0;
`ifdef MOD_REDUCE_EN
      bus.p = '0;
`endif
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.valid", {31'b0, bus.res_valid}, 32'd0);
      check("reset.res", {24'b0, bus.res}, 32'd0);
      check("reset.carry", {31'b0, bus.carry_out}, 32'd0);
      check("reset.ready", {31'b0, bus.start_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef MOD_REDUCE_EN
      run_op(1'b0, 8'hFA, 8'h02, 8'hFB, 8'h01, 1'b0, 0, "mod_add_wrap");
      run_op(1'b1, 8'h01, 8'h02, 8'hFB, 8'hFA, 1'b0, 0, "mod_sub_borrow");
      run_op(1'b0, 8'h10, 8'h20, 8'hFB, 8'h30, 1'b0, 5, "mod_add_plain");
      run_op(1'b0, 8'h7F, 8'h01, 8'hFB, 8'h80, 1'b0, 0, "mod_add_mid");
`else
      run_op(1'b0, 8'h7F, 8'h01, 8'h00, 8'h80, 1'b0, 0, "add_7f");
      run_op(1'b0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 0, "add_ff");
      run_op(1'b1, 8'h10, 8'h01, 8'h00, 8'h0F, 1'b1, 0, "sub_10");
      run_op(1'b1, 8'h01, 8'h02, 8'h00, 8'hFF, 1'b0, 5, "sub_borrow_bp");
`endif

      // Reset during RUN must abort with no result.
      bus.op_sub = 1'b0;
      bus.a = 8'h33;
      bus.b = 8'h44;
`ifdef MOD_REDUCE_EN
      bus.p = 8'hFB;
`endif
      bus.start_valid = 1'b1;
      @(negedge clk);
      bus.start_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst.valid", {31'b0, bus.res_valid}, 32'd0);
      check("midrst.res", {24'b0, bus.res}, 32'd0);
      check("midrst.carry", {31'b0, bus.carry_out}, 32'd0);
      check("midrst.ready", {31'b0, bus.start_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst.no_valid_after", {31'b0, bus.res_valid}, 32'd0);
      m = model(1'b0, 8'h33, 8'h44, 8'hFB);
      run_op(1'b0, 8'h33, 8'h44, 8'hFB, m[7:0], m[8], 0, "after_rst");

      for (int k = 0; k < 24; k++) begin
         rop = 1'($urandom);
`ifdef MOD_REDUCE_EN
         rp = 8'($urandom_range(2, 255));
         ra = 8'($urandom_range(0, int'(rp) - 1));
         rb = 8'($urandom_range(0, int'(rp) - 1));
`else
         rp = 8'h00;
         ra = 8'($urandom);
         rb = 8'($urandom);
`endif
         m = model(rop, int'(ra), int'(rb), int'(rp));
         run_op(rop, ra, rb, rp, m[7:0], m[8], int'($urandom_range(0, 2)), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
